// File: rtl/mac_err_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_err_sequencer_if
// Brief    : Operand stream and shared-multiplier bundle for the MAC sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface mac_err_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_weight;
    logic [7:0]  in_act;
    logic [7:0]  mul_weight;
    logic [7:0]  mul_act;
    logic [15:0] mul_product;
    logic        mul_err;

    // master: operand source plus the multiplier itself
    modport master (
        output in_valid, in_weight, in_act, mul_product, mul_err,
        input  in_ready, mul_weight, mul_act
    );

    modport slave (
        input  in_valid, in_weight, in_act, mul_product, mul_err,
        output in_ready, mul_weight, mul_act
    );
endinterface
`default_nettype wire

// File: rtl/mac_err_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mac_err_sequencer
// Brief    : Drives a shared 8x8 multiplier, accumulates a dot product and
//            replays products flagged by the multiplier's timing-error detector.
// Revision : 1.0 - initial release
// ============================================================================
module mac_err_sequencer #(
    parameter int ACC_W     = 24,
    parameter int LEN_W     = 8,
    parameter int MAX_RETRY = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    input  wire logic [LEN_W-1:0] len,
    mac_err_sequencer_if.slave    bus,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_W-1:0]      acc_out,
    output logic [7:0]            err_count,
    output logic                  overflow,
    output logic                  fail
);

    localparam int c_retry_w = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [c_retry_w-1:0] c_max_retry = c_retry_w'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_in_ready;
    logic [7:0]           r_mul_weight;
    logic [7:0]           r_mul_act;
    logic [ACC_W-1:0]     r_acc;
    logic [7:0]           r_err_count;
    logic                 r_overflow;
    logic                 r_fail;
    logic [LEN_W-1:0]     r_remaining;
    logic [c_retry_w-1:0] r_retry;

    logic [ACC_W:0]       w_sum;
    logic                 w_accept;
    logic [LEN_W-1:0]     w_rem_dec;
    logic [7:0]           w_err_inc;

    // Extra MSB of the sum is the accumulator carry-out
    assign w_sum     = {1'b0, r_acc} + (ACC_W+1)'(bus.mul_product);
    assign w_accept  = !bus.mul_err || (r_retry == c_max_retry);
    assign w_rem_dec = r_remaining - 1'b1;
    assign w_err_inc = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_in_ready   <= 1'b0;
            r_mul_weight <= '0;
            r_mul_act    <= '0;
            r_acc        <= '0;
            r_err_count  <= '0;
            r_overflow   <= 1'b0;
            r_fail       <= 1'b0;
            r_remaining  <= '0;
            r_retry      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc       <= '0;
                        r_err_count <= '0;
                        r_overflow  <= 1'b0;
                        r_fail      <= 1'b0;
                        r_remaining <= len;
                        r_retry     <= '0;
                        r_busy      <= 1'b1;
                        if (len != '0) begin
                            r_state    <= S_RUN;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (bus.in_valid) begin
                        r_mul_weight <= bus.in_weight;
                        r_mul_act    <= bus.in_act;
                        r_retry      <= '0;
                        r_in_ready   <= 1'b0;
                        r_state      <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (bus.mul_err) begin
                        r_err_count <= w_err_inc;
                        if (!w_accept) begin
                            r_retry <= r_retry + 1'b1;
                        end
                    end
                    // Accept clean products, or force-accept once the retries run out
                    if (w_accept) begin
                        r_acc       <= w_sum[ACC_W-1:0];
                        r_remaining <= w_rem_dec;
                        if (w_sum[ACC_W]) begin
                            r_overflow <= 1'b1;
                        end
                        if (bus.mul_err) begin
                            r_fail <= 1'b1;
                        end
                        if (w_rem_dec == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_RUN;
                            r_in_ready <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign acc_out        = r_acc;
    assign err_count      = r_err_count;
    assign overflow       = r_overflow;
    assign fail           = r_fail;
    assign bus.in_ready   = r_in_ready;
    assign bus.mul_weight = r_mul_weight;
    assign bus.mul_act    = r_mul_act;

endmodule
`default_nettype wire

// File: tb/tb_mac_err_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_err_sequencer
// Brief    : Lockstep bench for 24-bit and 16-bit accumulator instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_err_sequencer;

    localparam int MAX_RETRY = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] len = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_weight = '0;
    logic [7:0] in_act = '0;
    logic       mul_err = 1'b0;

    logic        busy_a, done_a, ov_a, fail_a;
    logic [23:0] acc_a;
    logic [7:0]  err_a;
    logic        busy_b, done_b, ov_b, fail_b;
    logic [15:0] acc_b;
    logic [7:0]  err_b;

    mac_err_sequencer_if ifa ();
    mac_err_sequencer_if ifb ();

    assign ifa.in_valid    = in_valid;
    assign ifa.in_weight   = in_weight;
    assign ifa.in_act      = in_act;
    assign ifa.mul_err     = mul_err;
    assign ifa.mul_product = 16'(ifa.mul_weight) * 16'(ifa.mul_act);
    assign ifb.in_valid    = in_valid;
    assign ifb.in_weight   = in_weight;
    assign ifb.in_act      = in_act;
    assign ifb.mul_err     = mul_err;
    assign ifb.mul_product = 16'(ifb.mul_weight) * 16'(ifb.mul_act);

    mac_err_sequencer #(.ACC_W(24), .LEN_W(8), .MAX_RETRY(MAX_RETRY)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bus(ifa),
        .busy(busy_a), .done(done_a), .acc_out(acc_a), .err_count(err_a),
        .overflow(ov_a), .fail(fail_a)
    );

    mac_err_sequencer #(.ACC_W(16), .LEN_W(8), .MAX_RETRY(MAX_RETRY)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bus(ifb),
        .busy(busy_b), .done(done_b), .acc_out(acc_b), .err_count(err_b),
        .overflow(ov_b), .fail(fail_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] acc;
        logic        ov24;
        logic [15:0] acc16;
        logic        ov16;
        logic [7:0]  errs;
        logic        fail;
    } exp_t;

    exp_t sb[$];
    int   pw[$];
    int   pa[$];
    int   pe[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One full operation; pe[i] = number of mul_err cycles raised on pair i
    task automatic run_op(input int n, input int gap);
        exp_t e;
        int   tot;
        int   ec;
        int   ne;
        int   k;
        bit   fl;
        tot = 0; ec = 0; fl = 1'b0;
        for (int i = 0; i < n; i++) begin
            tot += pw[i] * pa[i];
            if (pe[i] > MAX_RETRY) begin
                ec += MAX_RETRY + 1;
                fl = 1'b1;
            end else begin
                ec += pe[i];
            end
        end
        e.acc   = tot[23:0];
        e.ov24  = (tot >= 32'h0100_0000);
        e.acc16 = tot[15:0];
        e.ov16  = (tot >= 65536);
        e.errs  = ec[7:0];
        e.fail  = fl;
        sb.push_back(e);

        start = 1'b1; len = n[7:0];
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                for (int g = 0; g < gap; g++) begin
                    check_val("gap_ready", ifa.in_ready, 1);
                    check_val("gap_busy", busy_a, 1);
                    check_val("gap_acc", acc_a, 0);
                    @(negedge clk);
                end
            end
            check_val("run_ready", ifa.in_ready, 1);
            in_valid = 1'b1; in_weight = pw[i][7:0]; in_act = pa[i][7:0];
            @(negedge clk);
            in_valid = 1'b0;
            check_val("chk_ready", ifa.in_ready, 0);
            check_val("op_weight", ifa.mul_weight, pw[i]);
            check_val("op_act", ifa.mul_act, pa[i]);
            ne = (pe[i] > MAX_RETRY) ? MAX_RETRY + 1 : pe[i];
            for (int r = 0; r < ne; r++) begin
                mul_err = 1'b1;
                @(negedge clk);
                if (r < MAX_RETRY) begin
                    check_val("replay_weight", ifa.mul_weight, pw[i]);
                    check_val("replay_act", ifa.mul_act, pa[i]);
                    check_val("replay_ready", ifa.in_ready, 0);
                end
            end
            mul_err = 1'b0;
            if (pe[i] <= MAX_RETRY) @(negedge clk);
        end

        k = 0;
        while (k < 8 && !done_a) begin
            @(negedge clk);
            k++;
        end
        check_val("done_latency", k, 0);
        check_val("done_a", done_a, 1);
        check_val("done_b", done_b, 1);
        check_val("done_busy", busy_a, 1);
        check_val("done_ready", ifa.in_ready, 0);
        e = sb.pop_front();
        check_val("acc_a", acc_a, e.acc);
        check_val("ov_a", ov_a, e.ov24);
        check_val("err_a", err_a, e.errs);
        check_val("fail_a", fail_a, e.fail);
        check_val("acc_b", acc_b, e.acc16);
        check_val("ov_b", ov_b, e.ov16);
        check_val("err_b", err_b, e.errs);
        check_val("fail_b", fail_b, e.fail);
        @(negedge clk);
        check_val("post_done", done_a, 0);
        check_val("post_busy", busy_a, 0);
        check_val("post_acc", acc_a, e.acc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_val("rst_busy", busy_a, 0);
        check_val("rst_done", done_a, 0);
        check_val("rst_ready", ifa.in_ready, 0);
        check_val("rst_acc", acc_a, 0);
        check_val("rst_err", err_a, 0);
        check_val("rst_flags", {ov_a, fail_a}, 0);
        check_val("rst_opw", ifa.mul_weight, 0);
        rst_n = 1'b1;
        @(negedge clk);

        pw = {2, 4, 255};  pa = {3, 5, 255};  pe = {0, 0, 0};
        run_op(3, 0);

        pw = {}; pa = {}; pe = {};
        run_op(0, 0);

        pw = {10, 3};  pa = {10, 7};  pe = {0, 1};
        run_op(2, 0);

        pw = {9};  pa = {9};  pe = {3};
        run_op(1, 0);

        pw = {255, 255};  pa = {255, 255};  pe = {0, 0};
        run_op(2, 0);

        pw = {6, 11};  pa = {7, 13};  pe = {0, 0};
        run_op(2, 5);

        // Reset while the second pair of a four-pair operation sits in CHECK
        start = 1'b1; len = 8'd4;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_weight = 8'd7; in_act = 8'd7;
        @(negedge clk);
        in_valid = 1'b0; mul_err = 1'b1;
        @(negedge clk);
        mul_err = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_weight = 8'd5; in_act = 8'd6;
        @(negedge clk);
        in_valid = 1'b0;
        check_val("pre_rst_acc", acc_a, 49);
        check_val("pre_rst_err", err_a, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_val("mid_rst_busy", busy_a, 0);
        check_val("mid_rst_acc", acc_a, 0);
        check_val("mid_rst_ready", ifa.in_ready, 0);
        check_val("mid_rst_err", err_a, 0);
        check_val("mid_rst_opw", ifa.mul_weight, 0);
        check_val("mid_rst_busy_b", busy_b, 0);
        @(negedge clk);

        pw = {1, 2, 3, 4};  pa = {8, 9, 10, 11};  pe = {0, 2, 0, 0};
        run_op(4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
